seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Parametrised, time-multiplexed N-digit 7-segment display driver.
- Successor to the fixed 3-bit single-digit decoder: full hex decode (0-F), per-digit decimal point and blank, a refresh scan counter, anti-ghosting dead time, and tear-free double-buffered updates.
- Sits between datapath/control logic and the board display pins.
- Output packing is unchanged:
  - segs[6:0] = segments a..g
  - segs[7] = decimal point
  - segs[8+i] = enable of digit i
  - every output bit is active-low.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit stays selected; must be >= 2.
- DEAD_CYCLES, 2, cycles at the start of each digit slot with all digit enables off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe; captures value/dots/blank into the shadow registers
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 is rightmost
- dots  in  NUM_DIGITS  1 = decimal point on for digit i
- blank  in  NUM_DIGITS  1 = digit i fully dark (segments and dp off)
- segs  out  8+NUM_DIGITS  active-low; [6:0] a..g, [7] dp, [8+NUM_DIGITS-1:8] digit enables
- frame_tick  out  1  one-cycle pulse when the scan wraps from the last digit back to digit 0

Behaviour:
- Reset (sync, rst=1 at a clk edge): segs = all ones (everything dark); frame_tick=0; slot counter=0; digit index=0; shadow and display registers = 0.
  - Reset asserted mid-scan takes effect on the next edge, with no partial frame.
- Slot counter: counts 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0,1,..,NUM_DIGITS-1,0.
  - Index width is clog2(NUM_DIGITS), minimum 1 bit.
- Double buffer: load copies inputs into the shadow registers.
  - The display registers copy the shadow only at the frame boundary, i.e. the same edge where the index wraps to 0 and frame_tick pulses.
  - If load coincides with the frame boundary, the display registers take the newly presented inputs directly.
  - load held high for several cycles: the last sampled value wins.
- Digit enables: exactly one bit of segs[8+:NUM_DIGITS] is 0, at position = index, but only while slot counter >= DEAD_CYCLES.
  - During dead cycles all enable bits are 1.
  - Never more than one enable active.
- Segment/dp bits: registered decode of display nibble[index].
  - Pattern changes on the same edge as the index changes, so it is stable through the whole slot.
  - Blanked digit: segs[7:0]=8'hFF while its enable still scans.
- Active-low hex decode, segs[6:0] written as {g,f,e,d,c,b,a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- dp: segs[7] = ~dots[index] (display copy), forced to 1 when blanked.
- frame_tick is registered and high for exactly 1 cycle per NUM_DIGITS*REFRESH_DIV cycles.
- Output timing: all outputs are registered; no combinational path from inputs to segs.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
  - Defined: digits above the most significant nonzero nibble that hold 0 are treated as blanked, unless that digit's dot is set. Digit 0 is never suppressed, so value 0 shows a single "0". Evaluated on the display registers.
  - Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF (7'h7F)
  - the 16-entry active-low pattern constant array
  - the hex_to_seg function
  - the digit-index width helper
- Sub-module hex7seg_dec is purely combinational: 4-bit nibble in, 7-bit active-low pattern out.
- seg_scan_mux registers the output of hex7seg_dec.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset mid-scan → next edge segs=12'hFFF, frame_tick=0; after release digit 0 is the first selected, with segs[8]=0 from the 3rd cycle of the slot.
- load value=16'h81F0, dots=0, blank=0 → after the frame boundary, per slot:
  - digit0 segs[6:0]=40
  - digit1 = 0E
  - digit2 = 79
  - digit3 = 00
  - segs[7]=1 throughout.
- Scan timing → enables 1110,1101,1011,0111 each low for 6 of 8 cycles; frame_tick period = 32 cycles; never two enables low at once.
- load mid-frame with value=16'h1234 → old display persists until the boundary; new digits appear from the frame_tick edge onward, with no mixed frame.
- blank=4'b0100, dots=4'b0001 → digit2 segs[7:0]=FF with its enable still cycling; digit0 segs[7]=0.
- With SEG_LEADING_ZERO_BLANK_EN: value=16'h0050 → digits 3,2 dark, digit1=12, digit0=40; value=0 → only digit0 lit with pattern 40.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment scan driver.
//   SEG_OFF      : all segments dark (active-low)
//   SEG_LUT      : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   hex_to_seg   : nibble -> active-low pattern
//   idxWidth     : digit index width, minimum 1 bit
package seg_pkg;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction
    function automatic int idxWidth(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational hex to active-low 7-segment decoder.
//   nibble  in  4  hex digit
//   pattern out 7  active-low {g,f,e,d,c,b,a}
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    assign pattern = hex_to_seg(nibble);
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed N-digit 7-segment driver with dead time and double buffering.
//   clk, rst (sync active-high)
//   load        in   1-cycle strobe capturing value/dots/blank into the shadow registers
//   value       in   4*NUM_DIGITS hex nibbles, digit 0 rightmost
//   dots        in   per-digit decimal point enable
//   blank       in   per-digit blank
//   segs        out  active-low: [6:0] a..g, [7] dp, [8+:NUM_DIGITS] digit enables
//   frame_tick  out  1-cycle pulse when the scan wraps back to digit 0
// Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dots,
    input  logic [NUM_DIGITS-1:0]     blank,
    output logic [8+NUM_DIGITS-1:0]   segs,
    output logic                      frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = idxWidth(NUM_DIGITS);

    logic [CW-1:0]           slotCnt, slotNext;
    logic [IW-1:0]           digitIdx, idxNext;
    logic                    slotWrap, frameWrap;
    logic [4*NUM_DIGITS-1:0] shVal, dispVal, shValNext, dispValNext;
    logic [NUM_DIGITS-1:0]   shDots, shBlank, dispDots, dispBlank;
    logic [NUM_DIGITS-1:0]   shDotsNext, shBlankNext, dispDotsNext, dispBlankNext;
    logic [NUM_DIGITS-1:0]   blankEff, enNext;
    logic [3:0]              nibble;
    logic [6:0]              pattern;

    // Outputs are registered from the post-edge state so the pattern and the
    // enable always describe the same digit for the whole slot.
    always_comb begin
        slotWrap      = slotCnt == CW'(REFRESH_DIV - 1);
        frameWrap     = slotWrap && digitIdx == IW'(NUM_DIGITS - 1);
        slotNext      = slotWrap ? '0 : slotCnt + 1'b1;
        idxNext       = frameWrap ? '0 : slotWrap ? digitIdx + 1'b1 : digitIdx;
        shValNext     = load ? value : shVal;
        shDotsNext    = load ? dots : shDots;
        shBlankNext   = load ? blank : shBlank;
        // Using the shadow's next value lets a load on the boundary land directly.
        dispValNext   = frameWrap ? shValNext : dispVal;
        dispDotsNext  = frameWrap ? shDotsNext : dispDots;
        dispBlankNext = frameWrap ? shBlankNext : dispBlank;
        nibble        = dispValNext[{idxNext, 2'b00} +: 4];
        enNext        = '1;
        if (slotNext >= CW'(DEAD_CYCLES)) enNext[idxNext] = 1'b0;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic nzSeen;
    // Walk down from the top digit; zeros above the first nonzero nibble go dark
    // unless dotted. Digit 0 is never visited so a zero value still shows "0".
    always_comb begin
        nzSeen   = 1'b0;
        blankEff = dispBlankNext;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            nzSeen = nzSeen | (dispValNext[4*i +: 4] != 4'h0);
            if (!nzSeen && !dispDotsNext[i]) blankEff[i] = 1'b1;
        end
    end
`else
    assign blankEff = dispBlankNext;
`endif

    hex7seg_dec uDec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slotCnt    <= '0;
            digitIdx   <= '0;
            shVal      <= '0;
            shDots     <= '0;
            shBlank    <= '0;
            dispVal    <= '0;
            dispDots   <= '0;
            dispBlank  <= '0;
            segs       <= '1;
            frame_tick <= 1'b0;
        end else begin
            slotCnt    <= slotNext;
            digitIdx   <= idxNext;
            shVal      <= shValNext;
            shDots     <= shDotsNext;
            shBlank    <= shBlankNext;
            dispVal    <= dispValNext;
            dispDots   <= dispDotsNext;
            dispBlank  <= dispBlankNext;
            segs       <= {enNext, blankEff[idxNext] ? {1'b1, SEG_OFF} : {~dispDotsNext[idxNext], pattern}};
            frame_tick <= frameWrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized self-checking bench for seg_scan_mux against a time-based model.
module tb_seg_scan_mux;
    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = ND * RD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load = 1'b0;
    logic [4*ND-1:0] value = '0;
    logic [ND-1:0]   dots = '0;
    logic [ND-1:0]   blank = '0;
    logic [8+ND-1:0] segs;
    logic            frame_tick;

    int nCmp = 0;
    int nErr = 0;
    bit chkOn = 1'b0;

    seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dots       (dots),
        .blank      (blank),
        .segs       (segs),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: everything follows from k, the number of edges since reset.
    int              k = 0;
    logic [4*ND-1:0] mShVal, mDispVal;
    logic [ND-1:0]   mShDots, mShBlank, mDispDots, mDispBlank;
    logic [8+ND-1:0] expSegs;
    logic            expFt;

    always @(posedge clk) begin
        int dig;
        logic [ND-1:0] en;
        logic bl;
        if (rst) begin
            k = 0;
            mShVal = '0; mShDots = '0; mShBlank = '0;
            mDispVal = '0; mDispDots = '0; mDispBlank = '0;
            expSegs = '1;
            expFt = 1'b0;
        end else begin
            k++;
            if (load) begin
                mShVal = value; mShDots = dots; mShBlank = blank;
            end
            expFt = (k % FRAME) == 0;
            if (expFt) begin
                mDispVal = mShVal; mDispDots = mShDots; mDispBlank = mShBlank;
            end
            dig = (k / RD) % ND;
            en = '1;
            if ((k % RD) >= DC) en[dig] = 1'b0;
            bl = mDispBlank[dig];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (dig != 0 && (mDispVal >> (4 * dig)) == 0 && !mDispDots[dig]) bl = 1'b1;
`endif
            expSegs = {en, bl ? 8'hFF : {~mDispDots[dig], lut[mDispVal[dig*4 +: 4]]}};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkOn) begin
            chk("segs_model", segs, expSegs);
            chk("frame_tick_model", frame_tick, expFt);
            chk("enable_onehot", $countones(~segs[8 +: ND]) <= 1, 1);
        end
    end

    task automatic waitFrame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 4 * FRAME);
        if (!frame_tick) begin
            nErr++;
            $display("FAIL wait_frame_tick: got 0 expected 1 within %0d cycles", 4 * FRAME);
        end
    endtask

    task automatic pulseLoad(input logic [4*ND-1:0] v, input logic [ND-1:0] d, input logic [ND-1:0] b);
        value = v; dots = d; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chkOn = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_segs", segs, 12'hFFF);
        chk("reset_frame_tick", frame_tick, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("dead_cycle2_en0", segs[8], 1);
        @(negedge clk);
        chk("cycle3_en0", segs[8], 0);

        pulseLoad(16'h81F0, 4'b0000, 4'b0000);
        waitFrame();
        begin
            logic [6:0] exp81 [4] = '{7'h40, 7'h0E, 7'h79, 7'h00};
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("pat81F0_d%0d", d), segs[6:0], exp81[d]);
                chk($sformatf("dp81F0_d%0d", d), segs[7], 1);
                repeat (RD) @(negedge clk);
            end
        end
        chk("frame_period", frame_tick, 1);

        repeat (10) @(negedge clk);
        pulseLoad(16'h1234, 4'b0000, 4'b0000);
        chk("midframe_old_d1", segs[6:0], 7'h0E);
        waitFrame();
        chk("newframe_d0", segs[6:0], 7'h19);

        pulseLoad(16'h1234, 4'b0001, 4'b0100);
        waitFrame();
        chk("dot_d0", segs[7], 0);
        chk("dot_d0_pat", segs[6:0], 7'h19);
        repeat (2 * RD + 2) @(negedge clk);
        chk("blank_d2_segs", segs[7:0], 8'hFF);
        chk("blank_d2_enable", segs[10], 0);

`ifdef SEG_LEADING_ZERO_BLANK_EN
        pulseLoad(16'h0050, 4'b0000, 4'b0000);
        waitFrame();
        chk("lzb50_d0", segs[7:0], 8'hC0);
        repeat (RD) @(negedge clk);
        chk("lzb50_d1", segs[7:0], 8'h92);
        repeat (RD) @(negedge clk);
        chk("lzb50_d2", segs[7:0], 8'hFF);
        repeat (RD) @(negedge clk);
        chk("lzb50_d3", segs[7:0], 8'hFF);
        pulseLoad(16'h0000, 4'b0000, 4'b0000);
        waitFrame();
        chk("lzb0_d0", segs[7:0], 8'hC0);
        repeat (RD) @(negedge clk);
        chk("lzb0_d1", segs[7:0], 8'hFF);
`endif

        begin
            int hold = 0;
            for (int c = 0; c < 3000; c++) begin
                rst = $urandom_range(0, 499) == 0;
                if (hold > 0) begin
                    hold--;
                    load = 1'b1;
                end else begin
                    load = $urandom_range(0, 7) == 0;
                    if (load && $urandom_range(0, 3) == 0) hold = $urandom_range(1, 4);
                end
                value = 16'($urandom);
                dots  = 4'($urandom);
                blank = 4'($urandom & $urandom & $urandom);
                @(negedge clk);
            end
            rst = 1'b0;
            load = 1'b0;
            repeat (2 * FRAME) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
